// File: rtl/button_debouncer_bank_pkg.sv
// Shared board I/O constants and the debounce counter width helper.
package board_io_pkg;

    localparam int BUTTON_CHANNELS         = 4;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

    // Counter only has to reach cycles-1, so clog2(cycles) bits suffice.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/button_debouncer_bank_if.sv
// Button bank signal bundle: raw pins and acks in, debounced state and events out.
interface button_debouncer_bank_if
    import board_io_pkg::*;
#(
    parameter int WIDTH = BUTTON_CHANNELS
);
    logic [WIDTH-1:0] Buttons;
    logic [WIDTH-1:0] Ack;
    logic [WIDTH-1:0] Level;
    logic [WIDTH-1:0] Pressed;
    logic [WIDTH-1:0] Released;
    logic [WIDTH-1:0] Pending;
    logic             AnyPending;

    modport master (
        output Buttons, Ack,
        input  Level, Pressed, Released, Pending, AnyPending
    );

    modport slave (
        input  Buttons, Ack,
        output Level, Pressed, Released, Pending, AnyPending
    );
endinterface

// File: rtl/button_debouncer_bank_channel.sv
// One button: optional inversion, two-flop synchroniser, debounce counter,
// stable level register and registered press/release pulses.
module debounce_channel
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic level_o,
    output logic pressed_o,
    output logic released_o,
    output logic press_set_o
);
    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          pin_in;
    logic          s1_q, s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          pressed_q, pressed_d;
    logic          released_q, released_d;

    assign pin_in = (ACTIVE_LOW != 0) ? ~pin_i : pin_i;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        cnt_d      = '0;
        level_d    = level_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        if (s2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d    = s2_q;
                pressed_d  = s2_q;
                released_d = ~s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            s1_q       <= pin_in;
            s2_q       <= s1_q;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign level_o     = level_q;
    assign pressed_o   = pressed_q;
    assign released_o  = released_q;
    // Lets the bank set Pending on the same edge that registers Pressed.
    assign press_set_o = pressed_d;

endmodule

// File: rtl/button_debouncer_bank.sv
// Bank of independent debounced buttons with sticky, per-bit acknowledged
// press flags.
module button_debouncer_bank
    import board_io_pkg::*;
#(
    parameter int WIDTH           = BUTTON_CHANNELS,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                   Clock,
    input  logic                   Reset,
    button_debouncer_bank_if.slave bus
);
    logic [WIDTH-1:0] press_set;
    logic [WIDTH-1:0] pending_q, pending_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .clk_i       (Clock),
            .rst_i       (Reset),
            .pin_i       (bus.Buttons[i]),
            .level_o     (bus.Level[i]),
            .pressed_o   (bus.Pressed[i]),
            .released_o  (bus.Released[i]),
            .press_set_o (press_set[i])
        );
    end

    // A new press outranks a simultaneous ack so no event is lost.
    assign pending_d = (pending_q & ~bus.Ack) | press_set;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign bus.Pending    = pending_q;
    assign bus.AnyPending = |pending_q;

endmodule

// File: tb/tb_button_debouncer_bank.sv
// Scenario bench for button_debouncer_bank with DEBOUNCE_CYCLES=4, WIDTH=4,
// ACTIVE_LOW=0; expected output vectors are queued with their due edge.
module tb_button_debouncer_bank;

    typedef struct {
        int          at;
        logic [16:0] exp;
        string       tag;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t sb[$];

    always #5 Clock = ~Clock;

    button_debouncer_bank_if #(.WIDTH(4)) bus ();

    button_debouncer_bank #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (0)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    function automatic logic [16:0] observed();
        return {bus.Level, bus.Pressed, bus.Released, bus.Pending, bus.AnyPending};
    endfunction

    function automatic void expect_at(int at, logic [3:0] lv, logic [3:0] pr,
                                      logic [3:0] rl, logic [3:0] pd, string tag);
        exp_t e;
        e.at  = at;
        e.exp = {lv, pr, rl, pd, |pd};
        e.tag = tag;
        sb.push_back(e);
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        exp_t e;
        int   c = cyc;
        Reset       = 1'b1;
        bus.Buttons = 4'hf;
        bus.Ack     = 4'hf;
        for (int k = 1; k <= 6; k++) expect_at(c + k, 4'h0, 4'h0, 4'h0, 4'h0, "reset");
        for (int k = 0; k < 6; k++) begin
            if (k == 3) begin
                Reset       = 1'b0;
                bus.Buttons = 4'h0;
                bus.Ack     = 4'h0;
            end
            tick();
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                compared++;
                if (e.at != cyc || observed() !== e.exp) begin
                    mismatched++;
                    $display("FAIL %s @%0d: got %h expected %h", e.tag, e.at, observed(), e.exp);
                end
            end
        end
    endtask

    task automatic test_clean_press();
        exp_t e;
        int   c = cyc;
        expect_at(c + 5, 4'h0, 4'h0, 4'h0, 4'h0, "press_wait");
        expect_at(c + 6, 4'h1, 4'h1, 4'h0, 4'h1, "press_edge");
        expect_at(c + 7, 4'h1, 4'h0, 4'h0, 4'h1, "press_after");
        for (int k = 0; k < 7; k++) begin
            if (k == 0) bus.Buttons[0] = 1'b1;
            tick();
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                compared++;
                if (e.at != cyc || observed() !== e.exp) begin
                    mismatched++;
                    $display("FAIL %s @%0d: got %h expected %h", e.tag, e.at, observed(), e.exp);
                end
            end
        end
    endtask

    task automatic test_bounce();
        exp_t e;
        int   c = cyc;
        expect_at(c + 3,  4'h1, 4'h0, 4'h0, 4'h1, "bounce_quiet");
        expect_at(c + 6,  4'h1, 4'h0, 4'h0, 4'h1, "bounce_quiet");
        expect_at(c + 9,  4'h1, 4'h0, 4'h0, 4'h1, "bounce_quiet");
        expect_at(c + 10, 4'h3, 4'h2, 4'h0, 4'h3, "bounce_press");
        expect_at(c + 11, 4'h3, 4'h0, 4'h0, 4'h3, "bounce_after");
        for (int k = 0; k < 11; k++) begin
            bus.Buttons[1] = (k < 4) ? ((k % 2) == 0) : 1'b1;
            tick();
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                compared++;
                if (e.at != cyc || observed() !== e.exp) begin
                    mismatched++;
                    $display("FAIL %s @%0d: got %h expected %h", e.tag, e.at, observed(), e.exp);
                end
            end
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        int   c = cyc;
        for (int k = 1; k <= 9; k++) expect_at(c + k, 4'h3, 4'h0, 4'h0, 4'h3, "glitch");
        for (int k = 0; k < 9; k++) begin
            bus.Buttons[2] = (k < 3);
            tick();
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                compared++;
                if (e.at != cyc || observed() !== e.exp) begin
                    mismatched++;
                    $display("FAIL %s @%0d: got %h expected %h", e.tag, e.at, observed(), e.exp);
                end
            end
        end
    endtask

    task automatic test_ack_race();
        exp_t e;
        int   c = cyc;
        expect_at(c + 6,  4'h2, 4'h0, 4'h1, 4'h3, "release0_keeps_pending");
        expect_at(c + 12, 4'h2, 4'h0, 4'h0, 4'h3, "race_before");
        expect_at(c + 13, 4'h3, 4'h1, 4'h0, 4'h3, "race_set_wins");
        expect_at(c + 14, 4'h3, 4'h0, 4'h0, 4'h2, "race_ack_clears");
        expect_at(c + 15, 4'h3, 4'h0, 4'h0, 4'h0, "ack_clear_bit");
        expect_at(c + 16, 4'h3, 4'h0, 4'h0, 4'h0, "ack_idle");
        for (int k = 0; k < 16; k++) begin
            case (k)
                0:  bus.Buttons[0] = 1'b0;
                7:  bus.Buttons[0] = 1'b1;
                12: bus.Ack = 4'b0001;
                14: bus.Ack = 4'b0110;
                15: bus.Ack = 4'b0000;
                default: ;
            endcase
            tick();
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                compared++;
                if (e.at != cyc || observed() !== e.exp) begin
                    mismatched++;
                    $display("FAIL %s @%0d: got %h expected %h", e.tag, e.at, observed(), e.exp);
                end
            end
        end
    endtask

    task automatic test_multi_release();
        exp_t e;
        int   c = cyc;
        expect_at(c + 6,  4'hb, 4'h8, 4'h0, 4'h8, "press3");
        expect_at(c + 12, 4'hb, 4'h0, 4'h0, 4'h8, "multi_wait");
        expect_at(c + 13, 4'h2, 4'h0, 4'h9, 4'h8, "multi_release");
        expect_at(c + 14, 4'h2, 4'h0, 4'h0, 4'h8, "multi_after");
        for (int k = 0; k < 14; k++) begin
            if (k == 0) bus.Buttons[3] = 1'b1;
            if (k == 7) bus.Buttons = 4'b0010;
            tick();
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                compared++;
                if (e.at != cyc || observed() !== e.exp) begin
                    mismatched++;
                    $display("FAIL %s @%0d: got %h expected %h", e.tag, e.at, observed(), e.exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid_count();
        exp_t e;
        int   c = cyc;
        expect_at(c + 6,  4'h0, 4'h0, 4'h2, 4'h8, "release1");
        expect_at(c + 12, 4'h0, 4'h0, 4'h0, 4'h8, "count3");
        expect_at(c + 13, 4'h0, 4'h0, 4'h0, 4'h0, "reset_mid");
        expect_at(c + 18, 4'h0, 4'h0, 4'h0, 4'h0, "post_reset_wait");
        expect_at(c + 19, 4'h2, 4'h2, 4'h0, 4'h2, "post_reset_press");
        expect_at(c + 20, 4'h2, 4'h0, 4'h0, 4'h2, "post_reset_after");
        for (int k = 0; k < 20; k++) begin
            case (k)
                0:  bus.Buttons[1] = 1'b0;
                7:  bus.Buttons[1] = 1'b1;
                12: Reset = 1'b1;
                13: Reset = 1'b0;
                default: ;
            endcase
            tick();
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                compared++;
                if (e.at != cyc || observed() !== e.exp) begin
                    mismatched++;
                    $display("FAIL %s @%0d: got %h expected %h", e.tag, e.at, observed(), e.exp);
                end
            end
        end
    endtask

    initial begin
        exp_t e;
        Reset       = 1'b1;
        bus.Buttons = '0;
        bus.Ack     = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_ack_race();
        test_multi_release();
        test_reset_mid_count();
        while (sb.size() != 0) begin
            e = sb.pop_front();
            compared++;
            mismatched++;
            $display("FAIL %s @%0d: never compared, expected %h", e.tag, e.at, e.exp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/button_debouncer_bank.md
# button_debouncer_bank

Input-side counterpart to the LED output bank on the board top level. Takes raw, asynchronous, bouncing push-button inputs and delivers synchronised, debounced levels, single-cycle press/release pulses, and sticky pending-event flags with a per-bit acknowledge. Sits between the board pins and the SoC peripheral logic, clocked by the same `Clock` as the blinker counter.

## Interface
- `WIDTH`, 4 — number of button channels (1..32).
- `DEBOUNCE_CYCLES`, 250000 — consecutive cycles a new synchronised value must persist before acceptance (min 2).
- `ACTIVE_LOW`, 1 — when 1, pins are inverted before synchronisation, so a pressed button = logic 1 internally.

- `Clock`  in  1  — single system clock; all state on rising edge.
- `Reset`  in  1  — synchronous, active-high; sampled on `Clock` rising edge.
- `Buttons`  in  WIDTH  — raw pin inputs, asynchronous to `Clock`.
- `Ack`  in  WIDTH  — per-bit clear of `Pending`; level-sampled each cycle.
- `Level`  out  WIDTH  — debounced state, 1 = pressed.
- `Pressed`  out  WIDTH  — one-cycle pulse on debounced 0→1.
- `Released`  out  WIDTH  — one-cycle pulse on debounced 1→0.
- `Pending`  out  WIDTH  — sticky flag, set by `Pressed`, cleared by `Ack`.
- `AnyPending`  out  1  — OR-reduction of `Pending` (registered-equivalent: derived from registered `Pending`).

## Operation
- Per channel: optional inversion → two-flop synchroniser (`s1`, `s2`) → debounce counter `cnt` of width clog2(DEBOUNCE_CYCLES) → stable register (`Level`).
- Each cycle, per channel:
  - `s2 == Level`: `cnt <= 0`.
  - `s2 != Level` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - `s2 != Level` and `cnt == DEBOUNCE_CYCLES-1`: `Level <= s2`, `cnt <= 0`, and `Pressed` or `Released` is registered high for exactly that same cycle.
- Any return of `s2` to `Level` before acceptance restarts the count from 0; a glitch shorter than DEBOUNCE_CYCLES at `s2` never reaches `Level`.
- `Pending[i]`: set when `Pressed[i]`; cleared when `Ack[i]` and not `Pressed[i]`. Simultaneous set and ack: set wins (event not lost). `Ack` on a clear bit has no effect. `Released` never touches `Pending`.
- Channels fully independent; simultaneous events on several channels all reported in the same cycle.

## Timing
- Reset values: `s1`, `s2`, `cnt`, `Level`, `Pressed`, `Released`, `Pending` all 0; `AnyPending` 0. The synchroniser resets to the released (0) value, so a button held through reset produces a `Pressed` pulse DEBOUNCE_CYCLES+2 cycles after `Reset` deasserts.
- Latency: new value first sampled into `s1` at edge E0 and held; `Level` and pulse change after edge E0+DEBOUNCE_CYCLES+1. Example: D=4 → visible after E0+5.
- Pulses are registered, width exactly 1 cycle; `Pressed` and `Released` are never high on the same bit in the same cycle.
- `Pending` updates on the same edge that registers `Pressed` (visible together); `Ack` takes effect on the next edge.
- `Reset` mid-count or mid-pulse: all state returns to reset values on that edge; no pulse emitted afterwards for a count in progress.
- Counter never wraps: saturation is impossible because the accept condition resets it.

## Structure
- Shared package `board_io_pkg`: `DEBOUNCE_CYCLES_DEFAULT`, a `clog2`-based counter-width function, and the button-channel count constant used by the top level.
- One natural sub-module: `debounce_channel` (sync + counter + Level + pulses for one bit), instantiated WIDTH times via generate; `Pending`/`Ack` logic and `AnyPending` stay in the bank.

## Test plan
All with DEBOUNCE_CYCLES=4, WIDTH=4, ACTIVE_LOW=0.
- Clean press: `Buttons[0]` 0→1 sampled at edge E0, held → `Level[0]`, `Pressed[0]`, `Pending[0]` high after E0+5; `Pressed[0]` low after E0+6.
- Bounce: `Buttons[1]` toggles 1,0,1,0 at 1-cycle spacing then holds 1 → no pulse during bounce; single `Pressed[1]` 5 edges after the final rising sample.
- Glitch: `Buttons[2]` high for 3 cycles then low → `Level[2]`, `Pressed[2]`, `Pending[2]` stay 0 throughout.
- Ack race: `Pending[0]`=1, `Ack[0]` held high across a new `Pressed[0]` edge → `Pending[0]` remains 1 on the pulse edge; clears on the following edge; `AnyPending` tracks.
- Release and multi-channel: buttons 0 and 3 released on the same edge → `Released[0]` and `Released[3]` pulse together after 5 edges, `Pending` unchanged.
- Reset mid-operation: `Reset` asserted at count 3 with `Buttons[1]`=1 → all outputs 0 next edge; after deassert, `Pressed[1]` after 6 edges (2 sync + 4 count).
